// File: rtl/ddr3_sync_fifo_if.sv
// ---------------------------------------------------------------------------
// ddr3_sync_fifo_if
//   Bundles the data/handshake/status signals of ddr3_sync_fifo.
//   master : user side (drives din/wr_en/rd_en, observes data and flags)
//   slave  : FIFO side (observes requests, drives data and flags)
//   Signals:
//     din, wr_en, rd_en            write data and requests
//     dout, valid                  read data and its qualifier
//     full, almost_full, prog_full occupancy-high flags
//     empty, almost_empty, prog_empty occupancy-low flags
//     overflow, underflow          one-cycle rejected-request pulses
//     data_count                   occupancy 0..2**ADDR_W
// ---------------------------------------------------------------------------
interface ddr3_sync_fifo_if #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 8
);
    logic [DATA_W-1:0] din;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              valid;
    logic              full;
    logic              almost_full;
    logic              prog_full;
    logic              empty;
    logic              almost_empty;
    logic              prog_empty;
    logic              overflow;
    logic              underflow;
    logic [ADDR_W:0]   data_count;

    modport master (
        output din, wr_en, rd_en,
        input  dout, valid, full, almost_full, prog_full,
               empty, almost_empty, prog_empty, overflow, underflow, data_count
    );

    modport slave (
        input  din, wr_en, rd_en,
        output dout, valid, full, almost_full, prog_full,
               empty, almost_empty, prog_empty, overflow, underflow, data_count
    );
endinterface

// File: rtl/ddr3_sync_fifo.sv
// ---------------------------------------------------------------------------
// ddr3_sync_fifo
//   Single-clock FIFO buffering data between user logic and the DDR3
//   controller. Behavioural RAM with separate read/write pointers and an
//   explicit occupancy counter. Standard (1-cycle read latency) or
//   first-word-fall-through read mode, selected by FWFT.
//   Ports:
//     clk    clock, rising edge
//     rst_n  asynchronous reset, active low
//     srst   synchronous clear, active high, overrides wr_en/rd_en
//     bus    ddr3_sync_fifo_if.slave carrying data, requests and flags
// ---------------------------------------------------------------------------
module ddr3_sync_fifo #(
    parameter int DATA_W        = 512,
    parameter int ADDR_W        = 8,
    parameter int PROG_FULL_TH  = 240,
    parameter int PROG_EMPTY_TH = 8,
    parameter bit FWFT          = 1'b0
) (
    input logic             clk,
    input logic             rst_n,
    input logic             srst,
    ddr3_sync_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_CNT  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] PFULL_CNT  = (ADDR_W + 1)'(PROG_FULL_TH);
    localparam logic [ADDR_W:0] PEMPTY_CNT = (ADDR_W + 1)'(PROG_EMPTY_TH);
    localparam logic [ADDR_W:0] ONE_CNT    = (ADDR_W + 1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_next;
    logic [ADDR_W:0]   ram_count;
    logic [DATA_W-1:0] dout_r;
    logic              valid_r;
    logic              full_r;
    logic              almost_full_r;
    logic              prog_full_r;
    logic              empty_r;
    logic              almost_empty_r;
    logic              prog_empty_r;
    logic              overflow_r;
    logic              underflow_r;

    logic              wr_accept;
    logic              rd_accept;
    logic              readable;
    logic              ram_pop;
    logic              valid_next;

    // Accept decisions use only pre-edge state. In FWFT mode the word on
    // dout is counted in count but no longer lives in the RAM, so the RAM
    // occupancy is count minus the output register; the output register is
    // refilled from RAM whenever it is empty or being popped.
    always_comb begin
        ram_count  = FWFT ? (count - {{ADDR_W{1'b0}}, valid_r}) : count;
        readable   = FWFT ? valid_r : (ram_count != '0);
        wr_accept  = bus.wr_en & ~full_r;
        rd_accept  = bus.rd_en & readable;
        if (FWFT) begin
            ram_pop    = (~valid_r | rd_accept) & (ram_count != '0);
            valid_next = ram_pop | (valid_r & ~rd_accept);
        end else begin
            ram_pop    = rd_accept;
            valid_next = rd_accept;
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_next = count + ONE_CNT;
            2'b01:   count_next = count - ONE_CNT;
            default: count_next = count;
        endcase
    end

    // RAM write port; contents are deliberately never cleared.
    always_ff @(posedge clk) begin
        if (wr_accept && !srst) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // Pointers, output register and flags. Flags are computed from the
    // next occupancy so they line up with data_count after every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            dout_r         <= '0;
            valid_r        <= 1'b0;
            full_r         <= 1'b0;
            almost_full_r  <= 1'b0;
            prog_full_r    <= 1'b0;
            empty_r        <= 1'b1;
            almost_empty_r <= 1'b1;
            prog_empty_r   <= 1'b1;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
        end else if (srst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            dout_r         <= '0;
            valid_r        <= 1'b0;
            full_r         <= 1'b0;
            almost_full_r  <= 1'b0;
            prog_full_r    <= 1'b0;
            empty_r        <= 1'b1;
            almost_empty_r <= 1'b1;
            prog_empty_r   <= 1'b1;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (ram_pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
                dout_r <= mem[rd_ptr];
            end
            valid_r        <= valid_next;
            count          <= count_next;
            full_r         <= (count_next == DEPTH_CNT);
            almost_full_r  <= (count_next >= AFULL_CNT);
            prog_full_r    <= (count_next >= PFULL_CNT);
            empty_r        <= FWFT ? ~valid_next : (count_next == '0);
            almost_empty_r <= (count_next <= ONE_CNT);
            prog_empty_r   <= (count_next <= PEMPTY_CNT);
            overflow_r     <= bus.wr_en & ~wr_accept;
            underflow_r    <= bus.rd_en & ~rd_accept;
        end
    end

    assign bus.dout         = dout_r;
    assign bus.valid        = valid_r;
    assign bus.full         = full_r;
    assign bus.almost_full  = almost_full_r;
    assign bus.prog_full    = prog_full_r;
    assign bus.empty        = empty_r;
    assign bus.almost_empty = almost_empty_r;
    assign bus.prog_empty   = prog_empty_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;
    assign bus.data_count   = count;

endmodule

// File: tb/tb_ddr3_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_ddr3_sync_fifo
//   Self-checking bench for ddr3_sync_fifo. Three instances:
//     u_std : default parameters, standard read mode
//     u_sml : ADDR_W=4, PROG_FULL_TH=12, PROG_EMPTY_TH=3, standard mode
//     u_fw  : same sizing as u_sml, FWFT mode
//   Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_ddr3_sync_fifo;

    logic clk;
    logic rst_n;
    logic srst_std;
    logic srst_off;

    int test_count;
    int fail_count;

    ddr3_sync_fifo_if #(.DATA_W(512), .ADDR_W(8)) std_if ();
    ddr3_sync_fifo_if #(.DATA_W(16),  .ADDR_W(4)) sml_if ();
    ddr3_sync_fifo_if #(.DATA_W(16),  .ADDR_W(4)) fw_if ();

    ddr3_sync_fifo #(
        .DATA_W(512), .ADDR_W(8), .PROG_FULL_TH(240), .PROG_EMPTY_TH(8), .FWFT(1'b0)
    ) u_std (
        .clk(clk), .rst_n(rst_n), .srst(srst_std), .bus(std_if.slave)
    );

    ddr3_sync_fifo #(
        .DATA_W(16), .ADDR_W(4), .PROG_FULL_TH(12), .PROG_EMPTY_TH(3), .FWFT(1'b0)
    ) u_sml (
        .clk(clk), .rst_n(rst_n), .srst(srst_off), .bus(sml_if.slave)
    );

    ddr3_sync_fifo #(
        .DATA_W(16), .ADDR_W(4), .PROG_FULL_TH(12), .PROG_EMPTY_TH(3), .FWFT(1'b1)
    ) u_fw (
        .clk(clk), .rst_n(rst_n), .srst(srst_off), .bus(fw_if.slave)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts, and reports any mismatch
    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Flag equations derived from an expected occupancy
    task automatic check_flags(input string tag, input int depth, input int pf_th,
                               input int pe_th, input int cnt, input bit exp_empty,
                               input logic [8:0] dc, input logic full, input logic af,
                               input logic pf, input logic emp, input logic ae,
                               input logic pe);
        checkOutput($sformatf("%s.data_count", tag), 512'(dc), 512'(cnt));
        checkOutput($sformatf("%s.full", tag), 512'(full), 512'(cnt == depth));
        checkOutput($sformatf("%s.almost_full", tag), 512'(af), 512'(cnt >= depth - 1));
        checkOutput($sformatf("%s.prog_full", tag), 512'(pf), 512'(cnt >= pf_th));
        checkOutput($sformatf("%s.empty", tag), 512'(emp), 512'(exp_empty));
        checkOutput($sformatf("%s.almost_empty", tag), 512'(ae), 512'(cnt <= 1));
        checkOutput($sformatf("%s.prog_empty", tag), 512'(pe), 512'(cnt <= pe_th));
    endtask

    task automatic check_std(input string tag, input int cnt);
        check_flags(tag, 256, 240, 8, cnt, cnt == 0, std_if.data_count, std_if.full,
                    std_if.almost_full, std_if.prog_full, std_if.empty,
                    std_if.almost_empty, std_if.prog_empty);
    endtask

    task automatic check_std_reset(input string tag);
        check_std(tag, 0);
        checkOutput($sformatf("%s.dout", tag), std_if.dout, 512'(0));
        checkOutput($sformatf("%s.valid", tag), 512'(std_if.valid), 512'(0));
        checkOutput($sformatf("%s.overflow", tag), 512'(std_if.overflow), 512'(0));
        checkOutput($sformatf("%s.underflow", tag), 512'(std_if.underflow), 512'(0));
    endtask

    // Drive u_std for one edge and return 1 unit after it
    task automatic applyStimulus(input bit wr, input bit rd, input logic [511:0] d);
        std_if.wr_en = wr;
        std_if.rd_en = rd;
        std_if.din   = d;
        @(posedge clk);
        #1;
    endtask

    // Drive u_fw for one edge and return 1 unit after it
    task automatic applyFwft(input bit wr, input bit rd, input logic [15:0] d);
        fw_if.wr_en = wr;
        fw_if.rd_en = rd;
        fw_if.din   = d;
        @(posedge clk);
        #1;
    endtask

    // Distinct full-width pattern per word index
    function automatic logic [511:0] pat(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {64{b}};
    endfunction

    // Reference models for the randomised phase
    logic [15:0] s_q[$];
    logic [15:0] s_dout;
    bit          s_valid, s_ov, s_un, s_wa, s_ra, s_wr, s_rd;
    logic [15:0] f_q[$];
    logic [15:0] f_dout;
    bit          f_valid, f_ov, f_un, f_wa, f_ra, f_wr, f_rd;
    logic [15:0] s_din, f_din;
    int          f_cnt, pw, wr_seq, rd_seq;

    // Directed tests on u_std, FWFT directed tests on u_fw, then random
    // push/pop on the small instances against queue models.
    initial begin
        test_count = 0;
        fail_count = 0;
        rst_n = 1'b0;
        srst_std = 1'b0;
        srst_off = 1'b0;
        std_if.wr_en = 1'b0; std_if.rd_en = 1'b0; std_if.din = '0;
        sml_if.wr_en = 1'b0; sml_if.rd_en = 1'b0; sml_if.din = '0;
        fw_if.wr_en  = 1'b0; fw_if.rd_en  = 1'b0; fw_if.din  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_std_reset("reset");

        // Fill to full, checking every flag at every occupancy
        for (int k = 1; k <= 256; k++) begin
            applyStimulus(1'b1, 1'b0, pat(k - 1));
            check_std($sformatf("fill%0d", k), k);
        end
        applyStimulus(1'b1, 1'b0, pat(77));
        checkOutput("fill.overflow", 512'(std_if.overflow), 512'(1));
        checkOutput("fill.count_held", 512'(std_if.data_count), 512'(256));

        // Both requests at full: read wins, write rejected
        applyStimulus(1'b1, 1'b1, pat(88));
        checkOutput("full_rw.valid", 512'(std_if.valid), 512'(1));
        checkOutput("full_rw.dout", std_if.dout, pat(0));
        checkOutput("full_rw.overflow", 512'(std_if.overflow), 512'(1));
        checkOutput("full_rw.count", 512'(std_if.data_count), 512'(255));

        // Drain the remainder in order
        for (int i = 1; i <= 255; i++) begin
            applyStimulus(1'b0, 1'b1, '0);
            checkOutput($sformatf("drain%0d.valid", i), 512'(std_if.valid), 512'(1));
            checkOutput($sformatf("drain%0d.dout", i), std_if.dout, pat(i));
            check_std($sformatf("drain%0d", i), 255 - i);
            if (i == 1) begin
                checkOutput("drain.overflow_clear", 512'(std_if.overflow), 512'(0));
            end
        end
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("extra_rd.underflow", 512'(std_if.underflow), 512'(1));
        checkOutput("extra_rd.valid", 512'(std_if.valid), 512'(0));
        checkOutput("extra_rd.dout_hold", std_if.dout, pat(255));
        check_std("extra_rd", 0);

        // Both requests at empty: write accepted, read rejected
        wr_seq = 0;
        rd_seq = 0;
        applyStimulus(1'b1, 1'b1, pat(wr_seq));
        wr_seq++;
        checkOutput("empty_rw.count", 512'(std_if.data_count), 512'(1));
        checkOutput("empty_rw.underflow", 512'(std_if.underflow), 512'(1));
        checkOutput("empty_rw.valid", 512'(std_if.valid), 512'(0));

        // Build up to 100 then stream with simultaneous read/write
        for (int i = 0; i < 99; i++) begin
            applyStimulus(1'b1, 1'b0, pat(wr_seq));
            wr_seq++;
        end
        check_std("lvl100", 100);
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b1, 1'b1, pat(wr_seq));
            wr_seq++;
            checkOutput($sformatf("stream%0d.count", i), 512'(std_if.data_count), 512'(100));
            checkOutput($sformatf("stream%0d.dout", i), std_if.dout, pat(rd_seq));
            rd_seq++;
        end
        for (int i = 0; i < 63; i++) begin
            applyStimulus(1'b0, 1'b1, '0);
            checkOutput($sformatf("down%0d.dout", i), std_if.dout, pat(rd_seq));
            rd_seq++;
        end
        applyStimulus(1'b0, 1'b0, '0);
        check_std("lvl37", 37);
        checkOutput("lvl37.valid", 512'(std_if.valid), 512'(0));

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check_std_reset("async_rst");
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, pat(42));
        check_std("post_rst_wr", 1);
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("post_rst_rd.dout", std_if.dout, pat(42));
        checkOutput("post_rst_rd.valid", 512'(std_if.valid), 512'(1));

        // Synchronous clear beats a concurrent write
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, pat(10 + i));
        end
        check_std("pre_srst", 3);
        srst_std = 1'b1;
        applyStimulus(1'b1, 1'b0, pat(5));
        srst_std = 1'b0;
        check_std_reset("srst");
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("srst_rd.underflow", 512'(std_if.underflow), 512'(1));
        applyStimulus(1'b0, 1'b0, '0);

        // FWFT: word appears one cycle after the write without rd_en
        applyFwft(1'b1, 1'b0, 16'h00A5);
        checkOutput("fw_wr.count", 512'(fw_if.data_count), 512'(1));
        checkOutput("fw_wr.valid", 512'(fw_if.valid), 512'(0));
        checkOutput("fw_wr.empty", 512'(fw_if.empty), 512'(1));
        applyFwft(1'b0, 1'b0, '0);
        checkOutput("fw_show.valid", 512'(fw_if.valid), 512'(1));
        checkOutput("fw_show.dout", 512'(fw_if.dout), 512'(16'h00A5));
        checkOutput("fw_show.empty", 512'(fw_if.empty), 512'(0));
        applyFwft(1'b0, 1'b1, '0);
        checkOutput("fw_pop.valid", 512'(fw_if.valid), 512'(0));
        checkOutput("fw_pop.empty", 512'(fw_if.empty), 512'(1));
        checkOutput("fw_pop.count", 512'(fw_if.data_count), 512'(0));
        applyFwft(1'b0, 1'b1, '0);
        checkOutput("fw_under.underflow", 512'(fw_if.underflow), 512'(1));
        applyFwft(1'b1, 1'b0, 16'h0011);
        applyFwft(1'b1, 1'b0, 16'h0022);
        checkOutput("fw_two.dout", 512'(fw_if.dout), 512'(16'h0011));
        checkOutput("fw_two.count", 512'(fw_if.data_count), 512'(2));
        applyFwft(1'b0, 1'b1, '0);
        checkOutput("fw_next.dout", 512'(fw_if.dout), 512'(16'h0022));
        checkOutput("fw_next.valid", 512'(fw_if.valid), 512'(1));
        checkOutput("fw_next.count", 512'(fw_if.data_count), 512'(1));
        applyFwft(1'b0, 1'b1, '0);
        checkOutput("fw_last.valid", 512'(fw_if.valid), 512'(0));
        applyFwft(1'b0, 1'b0, '0);

        // Random wrap-around phase on the 16-deep instances
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        s_dout = '0; s_valid = 0;
        f_dout = '0; f_valid = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            pw = (((cyc / 500) % 2) == 0) ? 70 : 30;
            s_wr  = ($urandom_range(0, 99) < pw);
            s_rd  = ($urandom_range(0, 99) < (100 - pw));
            f_wr  = ($urandom_range(0, 99) < pw);
            f_rd  = ($urandom_range(0, 99) < (100 - pw));
            s_din = 16'($urandom);
            f_din = 16'($urandom);
            sml_if.wr_en = s_wr; sml_if.rd_en = s_rd; sml_if.din = s_din;
            fw_if.wr_en  = f_wr; fw_if.rd_en  = f_rd; fw_if.din  = f_din;

            s_wa = s_wr && (s_q.size() < 16);
            s_ra = s_rd && (s_q.size() > 0);
            s_ov = s_wr && !s_wa;
            s_un = s_rd && !s_ra;
            if (s_ra) begin
                s_dout  = s_q.pop_front();
                s_valid = 1;
            end else begin
                s_valid = 0;
            end
            if (s_wa) s_q.push_back(s_din);

            f_cnt = f_q.size() + int'(f_valid);
            f_wa = f_wr && (f_cnt < 16);
            f_ra = f_rd && f_valid;
            f_ov = f_wr && !f_wa;
            f_un = f_rd && !f_ra;
            if ((!f_valid || f_ra) && (f_q.size() > 0)) begin
                f_dout  = f_q.pop_front();
                f_valid = 1;
            end else if (f_ra) begin
                f_valid = 0;
            end
            if (f_wa) f_q.push_back(f_din);
            f_cnt = f_q.size() + int'(f_valid);

            @(posedge clk);
            #1;
            checkOutput("rs.dout", 512'(sml_if.dout), 512'(s_dout));
            checkOutput("rs.valid", 512'(sml_if.valid), 512'(s_valid));
            checkOutput("rs.overflow", 512'(sml_if.overflow), 512'(s_ov));
            checkOutput("rs.underflow", 512'(sml_if.underflow), 512'(s_un));
            check_flags("rs", 16, 12, 3, s_q.size(), s_q.size() == 0, 9'(sml_if.data_count),
                        sml_if.full, sml_if.almost_full, sml_if.prog_full, sml_if.empty,
                        sml_if.almost_empty, sml_if.prog_empty);
            checkOutput("rf.dout", 512'(fw_if.dout), 512'(f_dout));
            checkOutput("rf.valid", 512'(fw_if.valid), 512'(f_valid));
            checkOutput("rf.overflow", 512'(fw_if.overflow), 512'(f_ov));
            checkOutput("rf.underflow", 512'(fw_if.underflow), 512'(f_un));
            check_flags("rf", 16, 12, 3, f_cnt, !f_valid, 9'(fw_if.data_count),
                        fw_if.full, fw_if.almost_full, fw_if.prog_full, fw_if.empty,
                        fw_if.almost_empty, fw_if.prog_empty);
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
